// File: rtl/fc1_data_sink.sv
// fc1_data_sink: captures one fc1 output tensor from a valid/ready stream
// into local RAM and exposes it through a 2-stage registered read port.
module fc1_data_sink #(
  parameter int DATA_IN_TENSOR_SIZE_DIM_0 = 32,
  parameter int DATA_IN_TENSOR_SIZE_DIM_1 = 1,
  parameter int DATA_IN_PRECISION_0       = 16,
  parameter int DATA_IN_PRECISION_1       = 3,
  parameter int DATA_IN_PARALLELISM_DIM_0 = 1,
  parameter int DATA_IN_PARALLELISM_DIM_1 = 1,
  parameter int OUT_DEPTH =
    (DATA_IN_TENSOR_SIZE_DIM_0 * DATA_IN_TENSOR_SIZE_DIM_1) /
    (DATA_IN_PARALLELISM_DIM_0 * DATA_IN_PARALLELISM_DIM_1),
  parameter int READY_STALL_PERIOD = 0,
  parameter int AWIDTH = $clog2(OUT_DEPTH + 1),
  parameter int PAR =
    DATA_IN_PARALLELISM_DIM_0 * DATA_IN_PARALLELISM_DIM_1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_IN_PRECISION_0-1:0] data_in [PAR],
  input  logic                           data_in_valid,
  output logic                           data_in_ready,
  input  logic                           start,
  output logic                           done,
  output logic                           busy,
  output logic [AWIDTH-1:0]              beat_count,
  output logic [15:0]                    frame_count,
  input  logic                           rd_en,
  input  logic [AWIDTH-1:0]              rd_addr,
  output logic [DATA_IN_PRECISION_0-1:0] rd_data [PAR]
);

  localparam int P  = DATA_IN_PRECISION_0;
  localparam int W  = P * PAR;
  localparam int MW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam bit STALL_EN = READY_STALL_PERIOD > 1;
  localparam int SW =
    (READY_STALL_PERIOD > 2) ? $clog2(READY_STALL_PERIOD) : 1;
  localparam logic [SW-1:0] STALL_LAST =
    STALL_EN ? SW'(READY_STALL_PERIOD - 1) : '0;
  localparam logic [AWIDTH-1:0] LAST_BEAT = AWIDTH'(OUT_DEPTH - 1);
  localparam logic [AWIDTH-1:0] DEPTH_A   = AWIDTH'(OUT_DEPTH);

  // Fractional width is carried for downstream dump tools only.
  if (DATA_IN_PRECISION_1 > DATA_IN_PRECISION_0) begin : g_bad_frac
    $error("fc1_data_sink: fractional bits exceed element width");
  end

  if (OUT_DEPTH < 1) begin : g_bad_depth
    $error("fc1_data_sink: OUT_DEPTH must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    FULL    = 2'd2
  } state_e;

  state_e            state_q;
  logic              ready_q;
  logic              done_q;
  logic              busy_q;
  logic [AWIDTH-1:0] beat_q;
  logic [15:0]       frame_q;
  logic [SW-1:0]     stall_q;
  logic [SW-1:0]     stall_nx;
  logic              fire;

  logic [W-1:0] din_packed;
  logic [W-1:0] stage0_q;
  logic [W-1:0] rd_q;
  logic [W-1:0] mem [2**MW];

  always_comb begin
    din_packed = '0;
    for (int j = 0; j < PAR; j++) begin
      din_packed[P*j +: P] = data_in[j];
    end
  end

  always_comb begin
    for (int j = 0; j < PAR; j++) begin
      rd_data[j] = rd_q[P*j +: P];
    end
  end

  assign fire     = data_in_valid & ready_q;
  assign stall_nx = (stall_q == STALL_LAST) ? '0 : stall_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      beat_q  <= '0;
      frame_q <= '0;
      stall_q <= '0;
    end else begin
      unique case (state_q)
        IDLE, FULL: begin
          if (start) begin
            state_q <= CAPTURE;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
            beat_q  <= '0;
            stall_q <= '0;
          end
        end
        CAPTURE: begin
          stall_q <= stall_nx;
          // ready for the next cycle is decided from the next stall phase
          ready_q <= !(STALL_EN && stall_nx == STALL_LAST);
          if (fire) begin
            beat_q <= beat_q + 1'b1;
            if (beat_q == LAST_BEAT) begin
              state_q <= FULL;
              ready_q <= 1'b0;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              frame_q <= frame_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fire) begin
      mem[beat_q[MW-1:0]] <= din_packed;
    end
  end

  // Reads sample the RAM before this edge's write lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage0_q <= '0;
      rd_q     <= '0;
    end else if (rd_en) begin
      stage0_q <= (rd_addr < DEPTH_A) ? mem[rd_addr[MW-1:0]] : '0;
      rd_q     <= stage0_q;
    end
  end

  assign data_in_ready = ready_q;
  assign done          = done_q;
  assign busy          = busy_q;
  assign beat_count    = beat_q;
  assign frame_count   = frame_q;

endmodule

// File: tb/tb_fc1_data_sink.sv
// tb_fc1_data_sink: directed + randomized capture/readback checks
// for an unstalled sink and a sink stalling one cycle in four.
module tb_fc1_data_sink;

  localparam int P  = 16;
  localparam int D  = 32;
  localparam int AW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [P-1:0]  a_din [1];
  logic [P-1:0]  a_rd  [1];
  logic          a_v, a_rdy, a_start, a_done, a_busy, a_rden;
  logic [AW-1:0] a_bc, a_ra;
  logic [15:0]   a_fc;

  logic [P-1:0]  b_din [1];
  logic [P-1:0]  b_rd  [1];
  logic          b_v, b_rdy, b_start, b_done, b_busy, b_rden;
  logic [AW-1:0] b_bc, b_ra;
  logic [15:0]   b_fc;

  fc1_data_sink u_a (
    .clk           (clk),
    .rst           (rst),
    .data_in       (a_din),
    .data_in_valid (a_v),
    .data_in_ready (a_rdy),
    .start         (a_start),
    .done          (a_done),
    .busy          (a_busy),
    .beat_count    (a_bc),
    .frame_count   (a_fc),
    .rd_en         (a_rden),
    .rd_addr       (a_ra),
    .rd_data       (a_rd)
  );

  fc1_data_sink #(.READY_STALL_PERIOD(4)) u_b (
    .clk           (clk),
    .rst           (rst),
    .data_in       (b_din),
    .data_in_valid (b_v),
    .data_in_ready (b_rdy),
    .start         (b_start),
    .done          (b_done),
    .busy          (b_busy),
    .beat_count    (b_bc),
    .frame_count   (b_fc),
    .rd_en         (b_rden),
    .rd_addr       (b_ra),
    .rd_data       (b_rd)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [P-1:0] ref_a [D];
  logic [P-1:0] ref_b [D];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rd_a(input logic [AW-1:0] addr, input logic [P-1:0] exp,
                      input string tag);
    a_rden = 1'b1;
    a_ra   = addr;
    step();
    step();
    a_rden = 1'b0;
    chk(tag, a_rd[0], exp);
  endtask

  task automatic rd_b(input logic [AW-1:0] addr, input logic [P-1:0] exp,
                      input string tag);
    b_rden = 1'b1;
    b_ra   = addr;
    step();
    step();
    b_rden = 1'b0;
    chk(tag, b_rd[0], exp);
  endtask

  // Drives beats into u_a until 'stop' transfers are seen.
  task automatic cap_a(input bit rnd, input int stop, input int start_at,
                       input bit raw, input logic [P-1:0] base);
    int idx = 0;
    int rc = 0;
    int cyc = 0;
    int rawc = 0;
    bit xfer;
    logic [P-1:0] old3 = '0;
    a_v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    a_din[0] = rnd ? P'($urandom) : base;
    while (idx < stop && cyc < 500) begin
      chk("beat_count", 32'(a_bc), idx);
      chk("done_low", a_done, 0);
      chk("busy_high", a_busy, 1);
      a_start = (idx == start_at);
      xfer = a_v && a_rdy;
      if (a_rdy) rc++;
      if (raw && xfer && idx == 3) begin
        a_rden = 1'b1;
        a_ra   = 3;
        rawc   = 2;
        old3   = ref_a[3];
      end
      if (xfer) begin
        ref_a[idx] = a_din[0];
        idx++;
      end
      step();
      cyc++;
      a_start = 1'b0;
      if (rawc > 0) begin
        rawc--;
        if (rawc == 0) begin
          chk("raw_old_value", a_rd[0], old3);
          a_rden = 1'b0;
        end
      end
      if (xfer) a_din[0] = rnd ? P'($urandom) : base + P'(idx);
      if (xfer || !a_v) a_v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    chk("capture_timeout", idx, stop);
    if (!rnd && stop == D) chk("ready_cycles", rc, D);
  endtask

  initial begin
    int k;
    int idx;
    rst = 1'b1;
    a_v = 1'b0; a_start = 1'b0; a_rden = 1'b0; a_ra = '0; a_din[0] = '0;
    b_v = 1'b0; b_start = 1'b0; b_rden = 1'b0; b_ra = '0; b_din[0] = '0;
    @(negedge clk);
    step();
    step();
    chk("rst_ready", a_rdy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_beat", 32'(a_bc), 0);
    chk("rst_frame", 32'(a_fc), 0);
    chk("rst_rd", a_rd[0], 0);
    chk("rst_b_ready", b_rdy, 0);
    rst = 1'b0;
    step();
    chk("idle_ready", a_rdy, 0);

    // frame 1: payload = beat index, start pulsed at beat 10
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    chk("cap_ready", a_rdy, 1);
    cap_a(1'b0, D, 10, 1'b0, 16'h0000);
    chk("f1_done", a_done, 1);
    chk("f1_ready", a_rdy, 0);
    chk("f1_busy", a_busy, 0);
    chk("f1_beat", 32'(a_bc), D);
    chk("f1_frame", 32'(a_fc), 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("full_hold_ready", a_rdy, 0);
      chk("full_hold_beat", 32'(a_bc), D);
    end
    a_v = 1'b0;
    rd_a(AW'(5), 16'd5, "rd_addr5");
    a_ra = AW'(9);
    step();
    chk("rd_freeze", a_rd[0], 16'd5);

    // frame 2: restart from FULL with same-edge read/write at addr 3
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    chk("restart_done", a_done, 0);
    chk("restart_beat", 32'(a_bc), 0);
    chk("restart_ready", a_rdy, 1);
    cap_a(1'b0, D, -1, 1'b1, 16'h1000);
    a_v = 1'b0;
    chk("f2_frame", 32'(a_fc), 2);
    rd_a(AW'(3), 16'h1003, "reread3");
    rd_a(AW'(20), 16'h1014, "rd_addr20");

    // frame 3: random valid and payload
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    cap_a(1'b1, D, -1, 1'b0, 16'h0000);
    a_v = 1'b0;
    chk("f3_frame", 32'(a_fc), 3);
    chk("f3_done", a_done, 1);
    for (int i = 0; i < D; i++) rd_a(AW'(i), ref_a[i], "rd_random");

    // reset while capturing beat 17
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    cap_a(1'b0, 17, -1, 1'b0, 16'h2000);
    rst = 1'b1;
    step();
    rst = 1'b0;
    a_v = 1'b0;
    chk("mid_rst_ready", a_rdy, 0);
    chk("mid_rst_beat", 32'(a_bc), 0);
    chk("mid_rst_frame", 32'(a_fc), 0);
    chk("mid_rst_done", a_done, 0);
    chk("mid_rst_busy", a_busy, 0);
    chk("mid_rst_rd", a_rd[0], 0);

    // stalling sink: ready low every 4th capture cycle
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    b_v = 1'b1;
    b_din[0] = 16'h4000;
    k = 0;
    idx = 0;
    while (idx < D && k < 200) begin
      chk("stall_ready", b_rdy, (k % 4) != 3);
      if (b_rdy) begin
        ref_b[idx] = b_din[0];
        idx++;
      end
      step();
      k++;
      b_din[0] = 16'h4000 + P'(idx * 7);
    end
    b_v = 1'b0;
    chk("stall_cycles", k, 42);
    chk("stall_done", b_done, 1);
    chk("stall_frame", 32'(b_fc), 1);
    for (int i = 0; i < D; i++) rd_b(AW'(i), ref_b[i], "rd_stall");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
